// File: rtl/clock_skew_pkg.sv
// Shared constants, measurement state encoding and counter saturation helper
// for the clock skew observation block.
package clock_skew_pkg;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_LOCK_COUNT  = 4;

    // Measurement progress since reset: first rise arms, second yields a period.
    typedef enum logic [1:0] {
        MEAS_IDLE  = 2'd0,
        MEAS_ARMED = 2'd1,
        MEAS_VALID = 2'd2
    } meas_state_t;

    function automatic logic [31:0] cnt_sat_value(input int unsigned width);
        if (width >= 32)
            return '1;
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/clock_skew_design_sync_chain.sv
// N-stage single-bit synchroniser with synchronous reset; the input is treated
// as asynchronous data. STAGES must be at least 2.
module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (rst)
            stages <= '0;
        else
            stages <= {stages[STAGES-2:0], d};
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/clock_skew_design.sv
// Samples clk2 as data in the clk1 domain, measures its period in clk1 cycles
// and reports when that period is stable or when clk2 has stopped rising.
module clock_skew_design
    import clock_skew_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             clk2,
    output logic             q,
    output logic             rise,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(cnt_sat_value(CNT_W));
    localparam int unsigned       MCNT_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [MCNT_W-1:0] MCNT_LOCK = MCNT_W'(LOCK_COUNT);

    meas_state_t       state;
    meas_state_t       state_next;
    logic              measure;
    logic              q_d;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_sat;
    logic              period_match;
    logic [MCNT_W-1:0] mcnt;

    sync_chain #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk(clk1),
        .rst(rst),
        .d  (clk2),
        .q  (q)
    );

    assign cnt_sat      = (cnt == CNT_MAX);
    assign cnt_inc      = cnt_sat ? cnt : cnt + CNT_W'(1);
    assign period_match = (state == MEAS_VALID) && !cnt_sat && (cnt == period);

    always_comb begin
        state_next = state;
        measure    = 1'b0;
        case (state)
            MEAS_IDLE: begin
                if (rise)
                    state_next = MEAS_ARMED;
            end
            MEAS_ARMED: begin
                if (rise) begin
                    measure    = 1'b1;
                    state_next = MEAS_VALID;
                end
            end
            MEAS_VALID: begin
                measure = rise;
            end
            default: state_next = MEAS_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state  <= MEAS_IDLE;
            q_d    <= 1'b0;
            rise   <= 1'b0;
            cnt    <= '0;
            period <= '0;
            mcnt   <= '0;
        end else begin
            state <= state_next;
            q_d   <= q;
            rise  <= q & ~q_d;

            if (rise)
                cnt <= CNT_W'(1);
            else
                cnt <= cnt_inc;

            if (measure)
                period <= cnt;

            // mcnt is cleared on the same edge cnt saturates so locked never
            // overlaps timeout.
            if (measure) begin
                if (period_match)
                    mcnt <= (mcnt == MCNT_LOCK) ? mcnt : mcnt + MCNT_W'(1);
                else
                    mcnt <= '0;
            end else if (!rise && cnt_inc == CNT_MAX) begin
                mcnt <= '0;
            end
        end
    end

    assign period_valid = (state == MEAS_VALID);
    assign locked       = (mcnt == MCNT_LOCK);
    assign timeout      = cnt_sat;

endmodule

// File: tb/tb_clock_skew_design.sv
// Directed bench for clock_skew_design with default parameters; outputs are
// sampled 1 ns after each clk1 rising edge.
module tb_clock_skew_design;

    logic       clk1 = 1'b0;
    logic       rst  = 1'b1;
    logic       clk2 = 1'b0;
    logic       q;
    logic       rise;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       timeout;

    int checks = 0;
    int fails  = 0;

    clock_skew_design #(
        .SYNC_STAGES(2),
        .CNT_W      (8),
        .LOCK_COUNT (4)
    ) dut (
        .clk1        (clk1),
        .rst         (rst),
        .clk2        (clk2),
        .q           (q),
        .rise        (rise),
        .period      (period),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk1 = ~clk1;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        clk2 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        clk2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({q, rise, period, period_valid, locked, timeout} !== 13'd0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got %h expected 0", i,
                         {q, rise, period, period_valid, locked, timeout});
            end
            clk2 = ~clk2;
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({q, rise, period, period_valid, locked, timeout} !== 13'd0) begin
            fails++;
            $display("FAIL reset_release: got %h expected 0",
                     {q, rise, period, period_valid, locked, timeout});
        end
    endtask

    task automatic test_latency();
        do_reset();
        repeat (3) tick();
        clk2 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            checks++;
            if (q !== (e >= 2)) begin
                fails++;
                $display("FAIL latency_q[k+%0d]: got %b expected %b", e, q, e >= 2);
            end
            checks++;
            if (rise !== (e == 3)) begin
                fails++;
                $display("FAIL latency_rise[k+%0d]: got %b expected %b", e, rise, e == 3);
            end
        end
        checks++;
        if (period_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_first_rise_arms: period_valid got %b expected 0", period_valid);
        end
    endtask

    task automatic test_steady_period();
        do_reset();
        for (int c = 0; c < 28; c++) begin
            clk2 = ((c % 4) < 2);
            tick();
            checks++;
            if (timeout !== 1'b0) begin
                fails++;
                $display("FAIL steady_timeout[%0d]: got %b expected 0", c + 1, timeout);
            end
            if (c + 1 == 4) begin
                checks++;
                if (period_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL steady_arm_only: period_valid got %b expected 0", period_valid);
                end
            end
            if (c + 1 == 7) begin
                checks++;
                if (rise !== 1'b1) begin
                    fails++;
                    $display("FAIL steady_rise2: got %b expected 1", rise);
                end
            end
            if (c + 1 == 8) begin
                checks++;
                if ({period_valid, period} !== {1'b1, 8'd4}) begin
                    fails++;
                    $display("FAIL steady_period: got valid=%b period=%0d expected valid=1 period=4",
                             period_valid, period);
                end
            end
            if (c + 1 == 20) begin
                checks++;
                if (locked !== 1'b0) begin
                    fails++;
                    $display("FAIL steady_lock_early: got %b expected 0", locked);
                end
            end
            if (c + 1 == 24) begin
                checks++;
                if (locked !== 1'b1) begin
                    fails++;
                    $display("FAIL steady_lock: got %b expected 1", locked);
                end
            end
        end
    endtask

    task automatic test_same_freq_skew();
        do_reset();
        for (int i = 1; i <= 260; i++) begin
            @(posedge clk1);
            #1;
            checks++;
            if ({q, rise} !== 2'b00) begin
                fails++;
                $display("FAIL skew_q_rise[%0d]: got q=%b rise=%b expected 0 0", i, q, rise);
            end
            if (i == 254 || i == 255) begin
                checks++;
                if (timeout !== (i == 255)) begin
                    fails++;
                    $display("FAIL skew_timeout[%0d]: got %b expected %b", i, timeout, i == 255);
                end
            end
            #2 clk2 = 1'b1;
            #5 clk2 = 1'b0;
        end
        checks++;
        if ({locked, timeout} !== 2'b01) begin
            fails++;
            $display("FAIL skew_final: got locked=%b timeout=%b expected 0 1", locked, timeout);
        end
    endtask

    task automatic test_saturated_rise();
        for (int d = 0; d < 304; d++) begin
            clk2 = (d < 100) || (d >= 300);
            tick();
            if (d + 1 == 3 || d + 1 == 303) begin
                checks++;
                if ({rise, timeout} !== 2'b11) begin
                    fails++;
                    $display("FAIL sat_rise_with_timeout[%0d]: got rise=%b timeout=%b expected 1 1",
                             d + 1, rise, timeout);
                end
            end
            if (d + 1 == 4) begin
                checks++;
                if ({timeout, period_valid} !== 2'b00) begin
                    fails++;
                    $display("FAIL sat_rise_clears: got timeout=%b valid=%b expected 0 0",
                             timeout, period_valid);
                end
            end
            if (d + 1 == 257 || d + 1 == 258) begin
                checks++;
                if (timeout !== (d + 1 == 258)) begin
                    fails++;
                    $display("FAIL sat_timeout_edge[%0d]: got %b expected %b",
                             d + 1, timeout, d + 1 == 258);
                end
            end
            if (d + 1 == 304) begin
                checks++;
                if ({period, period_valid, locked, timeout} !== {8'd255, 1'b1, 1'b0, 1'b0}) begin
                    fails++;
                    $display("FAIL sat_period: got period=%0d valid=%b locked=%b timeout=%b expected 255 1 0 0",
                             period, period_valid, locked, timeout);
                end
            end
        end
    endtask

    task automatic test_period_change();
        do_reset();
        for (int c = 0; c < 60; c++) begin
            clk2 = (c < 24) ? ((c % 4) < 2) : (((c - 24) % 6) < 3);
            tick();
            if (c + 1 == 24 || c + 1 == 28 || c + 1 == 33) begin
                checks++;
                if ({locked, period} !== {1'b1, 8'd4}) begin
                    fails++;
                    $display("FAIL chg_locked4[%0d]: got locked=%b period=%0d expected 1 4",
                             c + 1, locked, period);
                end
            end
            if (c + 1 == 34 || c + 1 == 52) begin
                checks++;
                if ({locked, period} !== {1'b0, 8'd6}) begin
                    fails++;
                    $display("FAIL chg_unlocked6[%0d]: got locked=%b period=%0d expected 0 6",
                             c + 1, locked, period);
                end
            end
            if (c + 1 == 58) begin
                checks++;
                if ({locked, period} !== {1'b1, 8'd6}) begin
                    fails++;
                    $display("FAIL chg_relock6: got locked=%b period=%0d expected 1 6", locked, period);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            clk2 = ((c % 4) < 2);
            tick();
        end
        checks++;
        if (locked !== 1'b1) begin
            fails++;
            $display("FAIL mid_pre_locked: got %b expected 1", locked);
        end
        rst  = 1'b1;
        clk2 = 1'b0;
        tick();
        checks++;
        if ({q, rise, period, period_valid, locked, timeout} !== 13'd0) begin
            fails++;
            $display("FAIL mid_reset: got %h expected 0",
                     {q, rise, period, period_valid, locked, timeout});
        end
        rst = 1'b0;
        for (int c = 0; c < 28; c++) begin
            clk2 = ((c % 4) < 2);
            tick();
            if (c + 1 == 8) begin
                checks++;
                if ({period_valid, period} !== {1'b1, 8'd4}) begin
                    fails++;
                    $display("FAIL mid_reacq_period: got valid=%b period=%0d expected 1 4",
                             period_valid, period);
                end
            end
            if (c + 1 == 20 || c + 1 == 24) begin
                checks++;
                if (locked !== (c + 1 == 24)) begin
                    fails++;
                    $display("FAIL mid_reacq_lock[%0d]: got %b expected %b",
                             c + 1, locked, c + 1 == 24);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_steady_period();
        test_same_freq_skew();
        test_saturated_rise();
        test_period_change();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/clock_skew_design.md
# clock_skew_design

Single-clock monitor that samples a second, unrelated clock-like input (`clk2`) in the `clk1` domain. It exposes a synchronised copy of that input on `q` and measures its period in `clk1` cycles. It flags when that period is stable. It sits at a clock-domain boundary as a skew and phase observation point and produces no clock outputs.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth for `clk2`, minimum 2.
- `CNT_W`, 8: width of the period counter and the `period` output.
- `LOCK_COUNT`, 4: number of consecutive equal periods required to assert `locked`, minimum 1.

Ports:
- `clk1` input, 1 bit: the only clock. All state updates on its rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `clk2` input, 1 bit: asynchronous to `clk1` and treated purely as data. It never clocks any flop.
- `q` output, 1 bit: `clk2` after synchronisation.
- `rise` output, 1 bit: one-cycle pulse on each rising edge of `q`.
- `period` output, `CNT_W` bits: `clk1` cycles between the last two rises of `q`.
- `period_valid` output, 1 bit: set once at least two rises have been seen since reset.
- `locked` output, 1 bit: `period` has been stable for `LOCK_COUNT` consecutive measurements.
- `timeout` output, 1 bit: the running counter saturated without a rise.

## Operation
- **Synchroniser:** `clk2` passes through a shift chain of `SYNC_STAGES` flops. `q` is the last stage.
- **Edge detect:** `q_d` holds `q` delayed by one cycle. `rise` = `q & ~q_d`, registered so it is a clean one-cycle pulse.
- **Running counter `cnt`:**
  - Increments every cycle.
  - Saturates at 2^`CNT_W`−1. While saturated, `timeout`=1.
  - On `rise`: `cnt` is set to 1 and `timeout` is cleared.
- **First rise after reset:** arms measurement only. `period` and `period_valid` are unchanged.
- **Each later rise:**
  - `period` takes the value of `cnt` sampled before it resets.
  - `period_valid` is set to 1.
  - If `cnt` is saturated at that rise, `period` is still loaded (saturated value), but the measurement does not count toward lock.
- **Lock logic:** a match counter `mcnt` (range 0..`LOCK_COUNT`) tracks stable periods.
  - On each measured rise whose new period equals the previous `period` and is unsaturated: `mcnt` increments, saturating at `LOCK_COUNT`.
  - On any other measured rise: `mcnt` is set to 0.
  - `locked` = (`mcnt` == `LOCK_COUNT`).
  - While `timeout` is 1, `mcnt` is forced to 0, so `locked` is 0.
- **Constant `clk2`:** if `clk2` is stuck, or is sampled constant because it runs at the same frequency as `clk1`, there are no rises. `cnt` saturates, `timeout` goes to 1, and `locked` stays 0.

## Timing
- **Reset** (synchronous, highest priority): clears all synchroniser stages, `q_d`, `q`, `rise`, `cnt`, `period`, `period_valid`, `mcnt`, `locked`, `timeout` and the armed flag.
  - If `rst` is asserted mid-measurement, all of these are 0 on the next edge.
- **`q` latency:** `clk2` sampled at edge n appears on `q` after edge n+`SYNC_STAGES`−1 (n+1 for the default), i.e. `SYNC_STAGES` flops.
- **`rise`:** asserts one cycle after `q` rises and lasts exactly one cycle.
- **`period`, `period_valid`, `locked`:** update on the same edge on which `rise` is 1, i.e. one cycle after `rise` asserts.
- **Period measurement:** rises every P cycles produce `period` = P.
- **Lock time:** `locked` asserts on the (`LOCK_COUNT`+2)-th rise after reset when the period is steady.
  - The first rise arms, the second sets the reference, and each following one matches.
- **Precedence when a rise coincides with counter saturation:** the rise wins. `cnt` goes to 1 and `timeout` goes to 0.

## Structure
- A shared package `clock_skew_pkg` holds default parameter constants and the `cnt` saturation value function.
- One natural sub-module, `sync_chain`: a parameterised N-stage single-bit synchroniser with synchronous reset. It must carry async-register attributes for implementation tools.
- The top level contains edge detect, the counter, the period register and lock logic.

## Test plan
- **Reset:** hold `rst` high for 3 cycles with `clk2` toggling. Required: all outputs 0 throughout and on the first edge after release.
- **Latency:** step `clk2` 0→1 just after edge k, with default parameters. Required: `q`=1 after edge k+2, `rise`=1 for exactly one cycle after edge k+3.
- **Steady period:** drive `clk2` as `clk1`/4 (2 high, 2 low) with default parameters. Required: `period`=4 with `period_valid`=1 after the second rise; `locked`=1 after the sixth rise; `timeout` stays 0.
- **Same-frequency skew:** `clk2` has the same 10 ns period as `clk1`, offset 3 ns. Required: `q` constant 0, `rise` never asserts, `timeout`=1 after 255 cycles, `locked`=0.
- **Period change:** while locked at period 4, switch to period 6. Required: `locked` drops to 0 on the first period-6 measurement and reasserts `LOCK_COUNT` matching rises later.
- **Reset mid-run:** while locked, pulse `rst` for 1 cycle. Required: all outputs 0 on the next edge, then reacquisition follows the steady-period scenario.
